alu: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shifter.sv | 23 ++
 rtl/alu.sv | 64 ++++++
 tb/tb_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the alu: opcode map, shift-amount width, reserved result
// and the shifter mode encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  localparam int SHAMT_W     = 4;
  localparam int RESULT_RSVD = 0;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } sh_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
  input  sh_mode_e           mode,
  output logic [WIDTH-1:0]   res
);

  always_comb begin
    res = a;
    case (mode)
      SH_SLL:  res = a << amt;
      SH_SRL:  res = a >> amt;
      SH_SRA:  res = WIDTH'($signed(a) >>> amt);
      default: res = a;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: opcode decode mux feeding the out register (1-cycle latency).
// Define ALU_SHIFT_EN to build the shifter; otherwise opcodes 6-8 return 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] res;
  logic             lt_s, lt_u;

  assign lt_s = $signed(input_a) < $signed(input_b);
  assign lt_u = input_a < input_b;

`ifdef ALU_SHIFT_EN
  sh_mode_e         sh_mode;
  logic [WIDTH-1:0] sh_res;

  assign sh_mode = (op == OP_SRL) ? SH_SRL :
                   (op == OP_SRA) ? SH_SRA : SH_SLL;

  // Only the low SHAMT_W bits of B are a shift amount.
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a    (input_a),
    .amt  (input_b[SHAMT_W-1:0]),
    .mode (sh_mode),
    .res  (sh_res)
  );
`endif

  always_comb begin
    res = WIDTH'(RESULT_RSVD);
    case (op)
      OP_ADD:   res = input_a + input_b;
      OP_SUB:   res = input_a - input_b;
      OP_AND:   res = input_a & input_b;
      OP_OR:    res = input_a | input_b;
      OP_XOR:   res = input_a ^ input_b;
      OP_NOT:   res = ~input_a;
`ifdef ALU_SHIFT_EN
      OP_SLL,
      OP_SRL,
      OP_SRA:   res = sh_res;
`endif
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_PASSB: res = input_b;
      default:  res = WIDTH'(RESULT_RSVD);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) out <= '0;
    else       out <= res;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors plus random stimulus
// against an integer-arithmetic reference model.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] input_a, input_b, out;
  logic [3:0]  op;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] prev_exp;
  bit          have_prev = 1'b0;

  alu #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .input_a (input_a),
    .input_b (input_b),
    .op      (op),
    .out     (out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic on the opcode table.
  function automatic logic [15:0] ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, s, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    s  = ub % 16;
    r  = 0;
    case (o)
      4'd0:  r = (ua + ub) % 65536;
      4'd1:  r = (ua - ub + 65536) % 65536;
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = 65535 - ua;
`ifdef ALU_SHIFT_EN
      4'd6:  r = (ua * (1 << s)) % 65536;
      4'd7:  r = ua / (1 << s);
      4'd8:  r = ((sa >>> s) + 65536) % 65536;
`endif
      4'd9:  r = (sa < sb) ? 1 : 0;
      4'd10: r = (ua < ub) ? 1 : 0;
      4'd11: r = ub;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // Called just after a rising edge: drive inputs, confirm out has not moved
  // mid-cycle, then check the result one edge later.
  task automatic apply(input string tag, input logic r, input logic [3:0] o,
                       input logic [15:0] a, input logic [15:0] b);
    logic [15:0] exp;
    reset = r; op = o; input_a = a; input_b = b;
    #1;
    if (have_prev) chk({tag, "_hold"}, out, prev_exp);
    exp = r ? 16'h0000 : ref_alu(o, a, b);
    @(posedge clock);
    #1;
    chk(tag, out, exp);
    prev_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    reset = 1'b1; op = 4'd0; input_a = 16'd0; input_b = 16'd0;
    @(posedge clock);
    #1;

    apply("rst_add",  1'b1, 4'd0, 16'd5, 16'd7);
    chk("rst_zero", out, 16'h0000);
    apply("post_rst", 1'b0, 4'd0, 16'd5, 16'd7);
    chk("post_rst_12", out, 16'd12);

    apply("add00",   1'b0, 4'd0,  16'h0000, 16'h0000);
    apply("add11",   1'b0, 4'd0,  16'h0001, 16'h0001);
    apply("addwrap", 1'b0, 4'd0,  16'hFFFF, 16'h0001);
    chk("addwrap_0", out, 16'h0000);
    apply("sub01",   1'b0, 4'd1,  16'h0000, 16'h0001);
    chk("sub01_ffff", out, 16'hFFFF);
    apply("or01",    1'b0, 4'd3,  16'h0000, 16'h0001);
    apply("or00",    1'b0, 4'd3,  16'h0000, 16'h0000);
    apply("or11",    1'b0, 4'd3,  16'h0001, 16'h0001);
    apply("and10",   1'b0, 4'd2,  16'h0001, 16'h0000);
    apply("and11",   1'b0, 4'd2,  16'h0001, 16'h0001);
    apply("xor",     1'b0, 4'd4,  16'hF0F0, 16'h0FF0);
    chk("xor_ff00", out, 16'hFF00);
    apply("not0",    1'b0, 4'd5,  16'h0000, 16'hABCD);
    chk("not0_ffff", out, 16'hFFFF);
    apply("slt",     1'b0, 4'd9,  16'hFFFF, 16'h0001);
    chk("slt_1", out, 16'h0001);
    apply("sltu",    1'b0, 4'd10, 16'hFFFF, 16'h0001);
    chk("sltu_0", out, 16'h0000);
    apply("passb",   1'b0, 4'd11, 16'h5555, 16'h1234);
    chk("passb_1234", out, 16'h1234);
`ifdef ALU_SHIFT_EN
    apply("sll",     1'b0, 4'd6,  16'h0001, 16'd4);
    chk("sll_0010", out, 16'h0010);
    apply("srl",     1'b0, 4'd7,  16'h8000, 16'd15);
    chk("srl_1", out, 16'h0001);
    apply("sra",     1'b0, 4'd8,  16'h8000, 16'd4);
    chk("sra_f800", out, 16'hF800);
    apply("sll_hib", 1'b0, 4'd6,  16'h0001, 16'hFFF3);
    chk("sll_hib_8", out, 16'h0008);
    apply("sra0",    1'b0, 4'd8,  16'h9234, 16'h0000);
    chk("sra0_same", out, 16'h9234);
`else
    apply("sll_off", 1'b0, 4'd6,  16'h0001, 16'd4);
    chk("sll_off_0", out, 16'h0000);
    apply("sra_off", 1'b0, 4'd8,  16'h8000, 16'd4);
    chk("sra_off_0", out, 16'h0000);
`endif
    for (int o = 12; o < 16; o++) begin
      apply("rsvd", 1'b0, 4'(o), 16'($urandom), 16'($urandom));
      chk("rsvd_0", out, 16'h0000);
    end

    apply("rst_mid", 1'b1, 4'd11, 16'h1111, 16'h2222);
    apply("resume",  1'b0, 4'd11, 16'h1111, 16'h2222);

    // Op and operands change every cycle; occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = 16'h8000;
        1: b = 16'($urandom_range(0, 20));
        default: ;
      endcase
      apply("rand", ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
